// File: rtl/ptw_pkg.sv
// Shared types and constants for the page-table-walker memory responder.
package ptw_pkg;
  typedef logic [63:0] pte_t;

  localparam logic [2:0] MSIZE8 = 3'b011;

  typedef enum logic [1:0] {IDLE, BUS, RESP} resp_state_t;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
endpackage

// File: rtl/ptw_mem_responder_if.sv
// Walker-side request/response and walker data-bus read port, bundled together.
interface ptw_mem_responder_if;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [63:0] pte;
  logic        pte_valid;
  logic        flush;
  logic        bus_valid;
  logic [63:0] bus_addr;
  logic [2:0]  bus_size;
  logic        bus_data_ok;
  logic [63:0] bus_data;

  modport slave (
    input  mem_req, mem_addr, flush, bus_data_ok, bus_data,
    output pte, pte_valid, bus_valid, bus_addr, bus_size
  );

  modport master (
    output mem_req, mem_addr, flush, bus_data_ok, bus_data,
    input  pte, pte_valid, bus_valid, bus_addr, bus_size
  );
endinterface

// File: rtl/ptw_pte_cache.sv
// Small fully-associative PTE cache: parallel tag compare, round-robin fill.
module ptw_pte_cache
  import ptw_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 61
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output pte_t             hit_data,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag,
  input  pte_t             fill_data
);
  localparam int PW = $clog2(ENTRIES);

  logic [ENTRIES-1:0]            valid;
  logic [ENTRIES-1:0][TAG_W-1:0] tags;
  logic [ENTRIES-1:0][63:0]      data;
  logic [ENTRIES-1:0]            hit_vec;
  logic [PW-1:0]                 ptr;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
    assign hit_vec[gi] = valid[gi] && (tags[gi] == lookup_tag);
  end

  // Fills only happen on a miss, so at most one hit_vec bit is set.
  always_comb begin
    hit_data = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (hit_vec[i]) hit_data = hit_data | data[i];
  end

  assign hit = |hit_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      ptr   <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[ptr] <= 1'b1;
      ptr        <= ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en && !flush) begin
      tags[ptr] <= fill_tag;
      data[ptr] <= fill_data;
    end
  end
endmodule

// File: rtl/ptw_mem_responder.sv
// Serves walker PTE reads from the PTE cache, or via an 8-byte dbus read on a miss.
module ptw_mem_responder
  import ptw_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 61
) (
  input  logic               clk,
  input  logic               reset,
  ptw_mem_responder_if.slave io
);
  resp_state_t state;
  logic        live;
  logic        flushed;
  logic        hit;
  pte_t        hit_data;
  logic        fill_en;
  logic        live_now;

  assign live_now = live && io.mem_req;
  assign fill_en  = (state == BUS) && io.bus_data_ok && io.bus_data[PTE_V]
                    && !flushed && !io.flush;
  assign io.bus_size = MSIZE8;

  ptw_pte_cache #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) u_cache (
    .clk        (clk),
    .reset      (reset),
    .flush      (io.flush),
    .lookup_tag (io.mem_addr[63 -: TAG_W]),
    .hit        (hit),
    .hit_data   (hit_data),
    .fill_en    (fill_en),
    .fill_tag   (io.bus_addr[63 -: TAG_W]),
    .fill_data  (io.bus_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      io.pte       <= '0;
      io.pte_valid <= 1'b0;
      io.bus_valid <= 1'b0;
      io.bus_addr  <= '0;
      live         <= 1'b0;
      flushed      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          io.pte_valid <= 1'b0;
          if (io.mem_req) begin
            if (hit) begin
              io.pte       <= hit_data;
              io.pte_valid <= 1'b1;
              state        <= RESP;
            end else begin
              io.bus_addr  <= {io.mem_addr[63:3], 3'b000};
              io.bus_valid <= 1'b1;
              live         <= 1'b1;
              flushed      <= 1'b0;
              state        <= BUS;
            end
          end
        end
        BUS: begin
          // The read always runs to completion; a dropped request just suppresses the pulse.
          live    <= live_now;
          flushed <= flushed || io.flush;
          if (io.bus_data_ok) begin
            io.pte       <= io.bus_data;
            io.bus_valid <= 1'b0;
            io.pte_valid <= live_now;
            state        <= live_now ? RESP : IDLE;
          end
        end
        RESP: begin
          io.pte_valid <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          io.pte_valid <= 1'b0;
          io.bus_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ptw_mem_responder.sv
// Directed and randomized checks of ptw_mem_responder against a FIFO-ordered cache model.
module tb_ptw_mem_responder;
  localparam int ENTRIES = 4;

  typedef struct {
    logic [60:0] tag;
    logic [63:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;
  ent_t mq[$];

  ptw_mem_responder_if io();

  ptw_mem_responder #(.ENTRIES(ENTRIES), .TAG_W(61)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic bit mlook(input logic [63:0] a, output logic [63:0] d);
    d = '0;
    foreach (mq[i]) if (mq[i].tag == a[63:3]) begin d = mq[i].data; return 1'b1; end
    return 1'b0;
  endfunction

  // Round-robin over a flush-cleared array evicts in plain insertion order.
  task automatic mfill(input logic [63:0] a, input logic [63:0] d);
    ent_t e;
    e.tag = a[63:3];
    e.data = d;
    if (mq.size() == ENTRIES) void'(mq.pop_front());
    mq.push_back(e);
  endtask

  task automatic txn(input logic [63:0] addr, input int lat, input logic [63:0] data,
                     input bit drop, input bit fl);
    logic [63:0] ed;
    bit h;
    h = mlook(addr, ed);
    @(negedge clk);
    io.mem_req = 1'b1;
    io.mem_addr = addr;
    @(negedge clk);
    if (h) begin
      chk("hit_valid", io.pte_valid, 1);
      chk("hit_pte", io.pte, ed);
      chk("hit_nobus", io.bus_valid, 0);
      io.mem_req = 1'b0;
    end else begin
      for (int i = 0; i < lat; i++) begin
        if (i > 0) @(negedge clk);
        io.flush = 1'b0;
        chk("bus_valid", io.bus_valid, 1);
        chk("bus_addr", io.bus_addr, {addr[63:3], 3'b000});
        if (i == 0) chk("bus_size", io.bus_size, 3);
        if (i == 0 && fl) io.flush = 1'b1;
        if (i == 0 && drop) io.mem_req = 1'b0;
        if (i == lat - 1) begin
          io.bus_data_ok = 1'b1;
          io.bus_data = data;
        end
      end
      @(negedge clk);
      io.bus_data_ok = 1'b0;
      io.flush = 1'b0;
      if (fl) mq.delete();
      else if (data[0]) mfill(addr, data);
      chk("resp_valid", io.pte_valid, drop ? 0 : 1);
      chk("bus_done", io.bus_valid, 0);
      if (!drop) chk("resp_pte", io.pte, data);
      io.mem_req = 1'b0;
    end
    @(negedge clk);
    chk("pulse_end", io.pte_valid, 0);
  endtask

  task automatic flush_idle();
    @(negedge clk);
    io.flush = 1'b1;
    @(negedge clk);
    io.flush = 1'b0;
    mq.delete();
  endtask

  initial begin
    logic [63:0] a, d;
    io.mem_req = 1'b0;
    io.mem_addr = '0;
    io.flush = 1'b0;
    io.bus_data_ok = 1'b0;
    io.bus_data = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_pte_valid", io.pte_valid, 0);
    chk("rst_pte", io.pte, 0);
    chk("rst_bus_valid", io.bus_valid, 0);
    chk("rst_bus_addr", io.bus_addr, 0);
    reset = 1'b0;

    // Cold miss, then hit with ignored low bits
    txn(64'h8000_1008, 3, 64'h0000_0000_2000_0401, 0, 0);
    txn(64'h8000_100C, 1, 64'h0, 0, 0);
    chk("hit_after_fill", io.pte, 64'h0000_0000_2000_0401);

    // Invalid PTE is returned but not cached
    txn(64'h8000_2000, 2, 64'h0, 0, 0);
    txn(64'h8000_2000, 2, 64'h0, 0, 0);

    // Replacement: A0..A4 into 4 entries
    for (int i = 0; i < 5; i++)
      txn(64'h9000_0000 + 64'(i) * 8, 1, (64'(i) << 10) | 64'h1, 0, 0);
    for (int i = 4; i >= 0; i--)
      txn(64'h9000_0000 + 64'(i) * 8, 2, (64'(i) << 10) | 64'h3, 0, 0);

    // Flush mid-BUS blocks the fill but delivers the response
    txn(64'h8000_3000, 3, 64'h0000_0000_1234_5001, 0, 1);
    txn(64'h8000_3000, 2, 64'h0000_0000_1234_5001, 0, 0);

    // Flush in IDLE after 4 fills
    for (int i = 0; i < 4; i++) txn(64'hB000_0000 + 64'(i) * 8, 1, 64'h11 + 64'(i), 0, 0);
    flush_idle();
    for (int i = 0; i < 4; i++) txn(64'hB000_0000 + 64'(i) * 8, 1, 64'h21 + 64'(i), 0, 0);

    // Dropped request: no pulse, fill still happens
    txn(64'h8000_4000, 3, 64'h0000_0000_0000_0C01, 1, 0);
    txn(64'h8000_4000, 3, 64'h0, 0, 0);

    // Reset during BUS drops bus_valid at once and empties the cache
    @(negedge clk);
    io.mem_req = 1'b1;
    io.mem_addr = 64'h8000_5000;
    @(negedge clk);
    chk("pre_rst_bus", io.bus_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_bus_drop", io.bus_valid, 0);
    chk("async_bus_addr", io.bus_addr, 0);
    io.mem_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    txn(64'h8000_4000, 2, 64'h0000_0000_0000_0D01, 0, 0);

    // Randomized traffic over a small address pool
    for (int n = 0; n < 60; n++) begin
      a = 64'hA000_0000 + (64'($urandom_range(0, 7)) << 3) + 64'($urandom_range(0, 7));
      d = {$urandom, $urandom};
      d[0] = ($urandom_range(0, 3) != 0);
      txn(a, $urandom_range(1, 4), d, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ptw_mem_responder.md
Name: ptw_mem_responder

Overview:
- Memory-side responder for the Sv39 page-table walker's PTE read port.
- Accepts the walker's level-held request (mem_req / mem_addr) and returns one 64-bit PTE with a single-cycle pte_valid pulse.
- Serves hits from a small fully-associative PTE cache; misses go to an 8-byte read on a dedicated walker data-bus port.
- Sits between the walker and the dbus arbiter in the memory stage.

Parameters:
- ENTRIES, 4, number of PTE cache entries (power of two, ≥2).
- TAG_W, 61, tag width, equal to mem_addr[63:3].

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mem_req  in  1  walker request; held high while the walker waits.
- mem_addr  in  64  PTE physical address from the walker; bits [2:0] are ignored.
- pte  out  64  returned PTE, valid only while pte_valid=1.
- pte_valid  out  1  one-cycle response pulse.
- flush  in  1  invalidate the whole cache (sfence.vma or satp write).
- bus_valid  out  1  read request to the bus; held until bus_data_ok.
- bus_addr  out  64  {mem_addr[63:3], 3'b000}, captured at request start.
- bus_size  out  3  constant 3'b011 (8 bytes).
- bus_data_ok  in  1  read data returned this cycle.
- bus_data  in  64  read data.

Behaviour:
- Reset (asynchronous, active-high) values:
  - state=IDLE; pte_valid=0; pte=0; bus_valid=0; bus_addr=0.
  - All entry valid bits 0; replacement pointer 0.
- State machine: IDLE, BUS, RESP.
- IDLE:
  - If mem_req=1, compare mem_addr[63:3] against all valid tags.
  - Hit: latch entry data into pte; go to RESP. Latency is 1 cycle (request cycle → pte_valid cycle).
  - Miss: latch bus_addr; go to BUS. bus_valid rises on the next cycle.
- BUS:
  - bus_valid=1, bus_addr stable, until bus_data_ok=1.
  - On data_ok, capture bus_data into pte.
  - Go to RESP if the request is still live, else to IDLE.
- RESP:
  - pte_valid=1 for exactly this cycle, then IDLE.
  - The walker samples the pulse, updates its level on the same edge, and presents the next address in the next IDLE cycle. No back-to-back pulses are possible.
- Fill:
  - Happens on the data_ok cycle, only if bus_data[0]=1 (V bit) and no flush has occurred since BUS was entered.
  - Write {tag, data} to entry[ptr]; ptr increments modulo ENTRIES (round-robin).
  - Invalid PTEs are returned but never cached.
- Request-drop ("live" bit):
  - Set on entry to BUS; cleared if mem_req=0 on any BUS cycle.
  - The bus transaction is never aborted. It completes, then goes to IDLE with no pte_valid; the fill still happens if the fill rules hold.
- Flush:
  - Clears all valid bits at the next edge, with priority over a same-cycle fill.
  - A flush during BUS blocks the fill for that transaction; the response is still delivered if live.
  - A flush during IDLE or RESP has no effect on the response already latched.
- Duplicate tags: impossible by construction, since fills happen only on a miss. The hit mux is one-hot.
- Reset mid-transaction: state returns to IDLE immediately and bus_valid drops asynchronously. The bus side must tolerate an abandoned request.
- mem_req low in IDLE: no activity, all outputs hold their reset-like idle values; pte retains its last value.

Decomposition:
- Shared package ptw_pkg:
  - typedef pte_t (64-bit);
  - constant MSIZE8=3'b011;
  - state enum resp_state_t {IDLE, BUS, RESP};
  - constants for PTE bit positions (V=0, R/W/X=3:1).
- One sub-module: ptw_pte_cache.
  - Tag/data/valid arrays, parallel compare, hit and hit_data outputs.
  - Fill port with round-robin pointer; flush input.
- The FSM and bus logic stay in ptw_mem_responder.

Test Plan:
- Cold miss: mem_req=1, addr=0x8000_1008; bus returns 0x0000_0000_2000_0401 after 3 cycles → bus_valid high 3 cycles with bus_addr=0x8000_1008, size=3; pte_valid 1 cycle later with that data; entry filled.
- Hit after fill: repeat addr 0x8000_100C (low bits ignored) → no bus_valid, pte_valid on cycle+1 with 0x...2000_0401.
- Invalid PTE: miss returning 0x0 → pte_valid with 0; a second request to the same addr misses again (bus_valid asserted).
- Replacement: fill 5 distinct valid addresses A0–A4 with ENTRIES=4 → A0 misses afterwards, A1–A4 hit.
- Flush: flush=1 mid-BUS for addr B → response delivered, a later B request misses. Flush in IDLE after 4 fills → all miss.
- Drop and reset: mem_req falls during BUS → no pte_valid, returns to IDLE after data_ok. Assert reset during BUS → bus_valid=0 within the same cycle, state IDLE, cache empty.
